// File: rtl/frame_capture_pkg.sv
// Shared definitions for the OV7670 frame capture sequencer: FSM state encoding and default geometry.
package frame_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        SYNC    = 2'd2,
        CAPTURE = 2'd3
    } fsm_state_e;

    localparam int H_PIXELS_DEF = 320;
    localparam int V_LINES_DEF  = 240;
    localparam int LINE_W       = 9;

endpackage

// File: rtl/sync_edge_det.sv
// Registers camera vsync/href and derives the frame and line boundary strobes.
module sync_edge_det (
    input  logic pclk,
    input  logic reset,
    input  logic vsync,
    input  logic href,
    output logic vs_rise,
    output logic vs_fall,
    output logic href_fall
);

    logic vsync_d;
    logic href_d;

    always_ff @(posedge pclk) begin
        if (!reset) begin
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            vsync_d <= vsync;
            href_d  <= href;
        end
    end

    assign vs_rise   = vsync & ~vsync_d;
    assign vs_fall   = ~vsync & vsync_d;
    assign href_fall = ~href & href_d;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: arms on host request, aligns to frame start, counts and checks geometry.
// Optional bank ping-pong is built when FRAME_CAPTURE_DOUBLE_BUFFER_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start
// ARM     | waiting for vsync high so a frame in progress is skipped
// SYNC    | in vertical blank, waiting for vsync falling edge
// CAPTURE | frame active, strobes gated through and counted
module frame_capture_ctrl
    import frame_capture_pkg::*;
#(
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int V_LINES  = V_LINES_DEF,
    parameter int CNT_W    = 17
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic              stop,
    input  logic              vsync,
    input  logic              href,
    input  logic              pix_we,
    output logic              capture_en,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_error,
    output logic [LINE_W-1:0] line_count,
    output logic [CNT_W-1:0]  pixel_count,
    output logic [7:0]        frame_count
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_ARM     = ARM;
    localparam logic [1:0] S_SYNC    = SYNC;
    localparam logic [1:0] S_CAPTURE = CAPTURE;

    localparam logic [CNT_W-1:0]  PIX_MAX   = '1;
    localparam logic [LINE_W-1:0] LINE_MAX  = '1;
    localparam logic [CNT_W-1:0]  LINE_PIX  = CNT_W'(H_PIXELS);
    localparam logic [CNT_W-1:0]  FRAME_PIX = CNT_W'(H_PIXELS * V_LINES);
    localparam logic [LINE_W-1:0] FRAME_LN  = LINE_W'(V_LINES);

    logic vs_rise;
    logic vs_fall;
    logic href_fall;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic              mode_r;
    logic              stop_pend;
    logic              err_r;
    logic [CNT_W-1:0]  line_pix;
    logic [CNT_W-1:0]  pix_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [7:0]        frame_cnt;
    logic              cap_en_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;

    logic [CNT_W-1:0]  pix_nx;
    logic [CNT_W-1:0]  line_pix_nx;
    logic [LINE_W-1:0] line_nx;
    logic              err_nx;
    logic              frame_bad;
    logic              frame_end;
    logic              stop_nx;
    logic              arm_req;
    logic              sync_to_cap;

    sync_edge_det u_edge (
        .pclk      (pclk),
        .reset     (reset),
        .vsync     (vsync),
        .href      (href),
        .vs_rise   (vs_rise),
        .vs_fall   (vs_fall),
        .href_fall (href_fall)
    );

    // Next counter values include a strobe or line end landing on the vs_rise cycle.
    always_comb begin
        pix_nx      = pix_cnt;
        line_pix_nx = line_pix;
        line_nx     = line_cnt;
        err_nx      = err_r;
        if (pix_we) begin
            if (pix_cnt != PIX_MAX) pix_nx = pix_cnt + 1'b1;
            if (line_pix != PIX_MAX) line_pix_nx = line_pix + 1'b1;
        end
        if (href_fall) begin
            if (line_cnt != LINE_MAX) line_nx = line_cnt + 1'b1;
            if (line_pix_nx != LINE_PIX) err_nx = 1'b1;
            line_pix_nx = '0;
        end
    end

    assign frame_bad = err_nx
                     | (line_nx != FRAME_LN)
                     | (pix_nx != FRAME_PIX)
                     | (line_nx == LINE_MAX)
                     | (pix_nx == PIX_MAX);

    assign frame_end   = (state == S_CAPTURE) && vs_rise;
    assign stop_nx     = stop_pend | stop;
    assign arm_req     = (state == S_IDLE) && start && !stop;
    assign sync_to_cap = (state == S_SYNC) && (state_nx == S_CAPTURE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (arm_req) state_nx = S_ARM;
            end
            S_ARM: begin
                if (stop)       state_nx = S_IDLE;
                else if (vsync) state_nx = S_SYNC;
            end
            S_SYNC: begin
                if (stop)         state_nx = S_IDLE;
                else if (vs_fall) state_nx = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (frame_end) state_nx = (mode_r && !stop_nx) ? S_SYNC : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!reset) begin
            state     <= S_IDLE;
            mode_r    <= 1'b0;
            stop_pend <= 1'b0;
            err_r     <= 1'b0;
            line_pix  <= '0;
            pix_cnt   <= '0;
            line_cnt  <= '0;
            frame_cnt <= '0;
            cap_en_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            state    <= state_nx;
            cap_en_r <= (state_nx == S_CAPTURE);
            busy_r   <= (state_nx != S_IDLE);
            done_r   <= frame_end;
            error_r  <= frame_end & frame_bad;

            if (arm_req) mode_r <= continuous;

            if (state_nx == S_IDLE)
                stop_pend <= 1'b0;
            else if ((state == S_CAPTURE) && stop)
                stop_pend <= 1'b1;

            if (sync_to_cap) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
                line_pix <= '0;
                err_r    <= 1'b0;
            end else if (state == S_CAPTURE) begin
                pix_cnt  <= pix_nx;
                line_cnt <= line_nx;
                line_pix <= line_pix_nx;
                err_r    <= err_nx;
            end

            if (frame_end) frame_cnt <= frame_cnt + 1'b1;
        end
    end

`ifdef FRAME_CAPTURE_DOUBLE_BUFFER_EN
    logic wr_bank_r;

    // An errored frame keeps its bank so the next frame overwrites it.
    always_ff @(posedge pclk) begin
        if (!reset)
            wr_bank_r <= 1'b0;
        else if (frame_end && !frame_bad)
            wr_bank_r <= ~wr_bank_r;
    end

    assign wr_bank = wr_bank_r;
    assign rd_bank = ~wr_bank_r;
`else
    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;
`endif

    assign capture_en  = cap_en_r;
    assign busy        = busy_r;
    assign frame_done  = done_r;
    assign frame_error = error_r;
    assign line_count  = line_cnt;
    assign pixel_count = pix_cnt;
    assign frame_count = frame_cnt;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl with 4x3 geometry; follows FRAME_CAPTURE_DOUBLE_BUFFER_EN.
module tb_frame_capture_ctrl;

    localparam int HP = 4;
    localparam int VL = 3;
    localparam int CW = 17;
`ifdef FRAME_CAPTURE_DOUBLE_BUFFER_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          stop = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic          pix_we = 1'b0;
    logic          capture_en;
    logic          wr_bank;
    logic          rd_bank;
    logic          busy;
    logic          frame_done;
    logic          frame_error;
    logic [8:0]    line_count;
    logic [CW-1:0] pixel_count;
    logic [7:0]    frame_count;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;
    logic exp_wr = 1'b0;

    frame_capture_ctrl #(.H_PIXELS(HP), .V_LINES(VL), .CNT_W(CW)) dut (
        .pclk        (pclk),
        .reset       (reset),
        .start       (start),
        .continuous  (continuous),
        .stop        (stop),
        .vsync       (vsync),
        .href        (href),
        .pix_we      (pix_we),
        .capture_en  (capture_en),
        .wr_bank     (wr_bank),
        .rd_bank     (rd_bank),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_error (frame_error),
        .line_count  (line_count),
        .pixel_count (pixel_count),
        .frame_count (frame_count)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) if (frame_done === 1'b1) done_seen++;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic do_line(input int npix);
        href = 1'b1;
        for (int i = 0; i < npix; i++) begin
            pix_we = 1'b1;
            tick();
        end
        pix_we = 1'b0;
        tick();
        href = 1'b0;
        tick(2);
    endtask

    task automatic vblank();
        vsync = 1'b1;
        tick(3);
        vsync = 1'b0;
        tick(2);
    endtask

    task automatic end_frame();
        vsync = 1'b1;
        tick();
    endtask

    task automatic frame(input int p0, input int p1, input int p2);
        vblank();
        do_line(p0);
        do_line(p1);
        do_line(p2);
        end_frame();
    endtask

    task automatic pulse_start(input logic cont);
        start = 1'b1;
        continuous = cont;
        tick();
        start = 1'b0;
        continuous = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick();
        n_cmp++; if (capture_en !== 1'b0) begin n_bad++; $display("FAIL rst_capture_en: got %b want 0", capture_en); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (frame_done !== 1'b0 || frame_error !== 1'b0) begin n_bad++; $display("FAIL rst_done_err: got %b%b want 00", frame_done, frame_error); end
        n_cmp++; if (line_count !== 9'd0 || pixel_count !== 17'd0 || frame_count !== 8'd0) begin n_bad++; $display("FAIL rst_counts: got %0d/%0d/%0d want 0/0/0", line_count, pixel_count, frame_count); end
        n_cmp++; if (wr_bank !== 1'b0 || rd_bank !== DBUF) begin n_bad++; $display("FAIL rst_banks: got wr=%b rd=%b want wr=0 rd=%b", wr_bank, rd_bank, DBUF); end
    endtask

    task automatic test_single();
        int d0;
        d0 = done_seen;
        pulse_start(1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_arm: got %b want 1", busy); end
        vblank();
        n_cmp++; if (capture_en !== 1'b1) begin n_bad++; $display("FAIL single_capen: got %b want 1", capture_en); end
        do_line(HP); do_line(HP); do_line(HP);
        end_frame();
        if (DBUF) exp_wr = ~exp_wr;
        n_cmp++; if (frame_done !== 1'b1 || frame_error !== 1'b0) begin n_bad++; $display("FAIL single_done_err: got %b%b want 10", frame_done, frame_error); end
        n_cmp++; if (line_count !== 9'd3 || pixel_count !== 17'd12) begin n_bad++; $display("FAIL single_counts: got %0d/%0d want 3/12", line_count, pixel_count); end
        n_cmp++; if (busy !== 1'b0 || capture_en !== 1'b0) begin n_bad++; $display("FAIL single_idle: got busy=%b capen=%b want 0 0", busy, capture_en); end
        n_cmp++; if (frame_count !== 8'd1) begin n_bad++; $display("FAIL single_fcount: got %0d want 1", frame_count); end
        n_cmp++; if (wr_bank !== exp_wr || rd_bank !== (DBUF & ~exp_wr)) begin n_bad++; $display("FAIL single_banks: got wr=%b rd=%b want wr=%b", wr_bank, rd_bank, exp_wr); end
        tick();
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL single_done_pulse: got %b want 0", frame_done); end
        n_cmp++; if (done_seen - d0 !== 1) begin n_bad++; $display("FAIL single_done_cnt: got %0d want 1", done_seen - d0); end
    endtask

    task automatic test_mid_start();
        int d0;
        vsync = 1'b0;
        tick(2);
        d0 = done_seen;
        pulse_start(1'b0);
        do_line(HP);
        n_cmp++; if (capture_en !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_armed: got capen=%b busy=%b want 0 1", capture_en, busy); end
        do_line(HP);
        vsync = 1'b1;
        tick(3);
        n_cmp++; if (capture_en !== 1'b0) begin n_bad++; $display("FAIL mid_vblank_capen: got %b want 0", capture_en); end
        vsync = 1'b0;
        tick();
        n_cmp++; if (capture_en !== 1'b1) begin n_bad++; $display("FAIL mid_capen_rise: got %b want 1", capture_en); end
        tick();
        do_line(HP); do_line(HP); do_line(HP);
        end_frame();
        if (DBUF) exp_wr = ~exp_wr;
        n_cmp++; if (frame_done !== 1'b1 || frame_error !== 1'b0 || pixel_count !== 17'd12) begin n_bad++; $display("FAIL mid_frame: got done=%b err=%b pix=%0d want 1 0 12", frame_done, frame_error, pixel_count); end
        n_cmp++; if (wr_bank !== exp_wr) begin n_bad++; $display("FAIL mid_bank: got %b want %b", wr_bank, exp_wr); end
        tick();
        n_cmp++; if (done_seen - d0 !== 1) begin n_bad++; $display("FAIL mid_done_cnt: got %0d want 1", done_seen - d0); end
    endtask

    task automatic test_short_line();
        pulse_start(1'b0);
        frame(HP, HP - 1, HP);
        n_cmp++; if (frame_done !== 1'b1 || frame_error !== 1'b1) begin n_bad++; $display("FAIL short_done_err: got %b%b want 11", frame_done, frame_error); end
        n_cmp++; if (pixel_count !== 17'd11 || line_count !== 9'd3) begin n_bad++; $display("FAIL short_counts: got %0d/%0d want 11/3", pixel_count, line_count); end
        n_cmp++; if (wr_bank !== exp_wr || rd_bank !== (DBUF & ~exp_wr)) begin n_bad++; $display("FAIL short_banks: got wr=%b rd=%b want wr=%b", wr_bank, rd_bank, exp_wr); end
        n_cmp++; if (frame_count !== 8'd3) begin n_bad++; $display("FAIL short_fcount: got %0d want 3", frame_count); end
        tick();
    endtask

    task automatic test_continuous();
        int d0;
        d0 = done_seen;
        pulse_start(1'b1);
        for (int f = 0; f < 2; f++) begin
            frame(HP, HP, HP);
            if (DBUF) exp_wr = ~exp_wr;
            n_cmp++; if (frame_done !== 1'b1 || frame_error !== 1'b0) begin n_bad++; $display("FAIL cont_done_err%0d: got %b%b want 10", f, frame_done, frame_error); end
            n_cmp++; if (busy !== 1'b1 || capture_en !== 1'b0) begin n_bad++; $display("FAIL cont_rearm%0d: got busy=%b capen=%b want 1 0", f, busy, capture_en); end
        end
        vblank();
        do_line(HP);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++; if (busy !== 1'b1 || capture_en !== 1'b1) begin n_bad++; $display("FAIL cont_stop_hold: got busy=%b capen=%b want 1 1", busy, capture_en); end
        do_line(HP); do_line(HP);
        end_frame();
        if (DBUF) exp_wr = ~exp_wr;
        n_cmp++; if (frame_done !== 1'b1 || frame_error !== 1'b0) begin n_bad++; $display("FAIL cont_last_done: got %b%b want 10", frame_done, frame_error); end
        n_cmp++; if (busy !== 1'b0 || frame_count !== 8'd6) begin n_bad++; $display("FAIL cont_end: got busy=%b fcount=%0d want 0 6", busy, frame_count); end
        n_cmp++; if (wr_bank !== exp_wr) begin n_bad++; $display("FAIL cont_bank: got %b want %b", wr_bank, exp_wr); end
        tick();
        n_cmp++; if (done_seen - d0 !== 3) begin n_bad++; $display("FAIL cont_done_cnt: got %0d want 3", done_seen - d0); end
    endtask

    task automatic test_start_stop();
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ss_same_cycle: got busy=%b want 0", busy); end
        tick(2);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ss_stay_idle: got busy=%b want 0", busy); end
        pulse_start(1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ss_stop_arm: got busy=%b want 0", busy); end
        pulse_start(1'b0);
        pulse_start(1'b1);
        n_cmp++; if (busy !== 1'b1 || capture_en !== 1'b0) begin n_bad++; $display("FAIL ss_start_busy: got busy=%b capen=%b want 1 0", busy, capture_en); end
        frame(HP, HP, HP);
        if (DBUF) exp_wr = ~exp_wr;
        n_cmp++; if (frame_done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL ss_single_kept: got done=%b busy=%b want 1 0", frame_done, busy); end
        n_cmp++; if (frame_count !== 8'd7) begin n_bad++; $display("FAIL ss_fcount: got %0d want 7", frame_count); end
        tick();
    endtask

    task automatic test_reset_mid();
        int d0;
        pulse_start(1'b0);
        vblank();
        do_line(HP); do_line(HP);
        n_cmp++; if (line_count !== 9'd2 || pixel_count !== 17'd8 || capture_en !== 1'b1) begin n_bad++; $display("FAIL rmid_live: got ln=%0d pix=%0d capen=%b want 2 8 1", line_count, pixel_count, capture_en); end
        reset = 1'b0;
        tick();
        exp_wr = 1'b0;
        n_cmp++; if (capture_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || frame_error !== 1'b0) begin n_bad++; $display("FAIL rmid_flags: got capen=%b busy=%b done=%b err=%b want 0000", capture_en, busy, frame_done, frame_error); end
        n_cmp++; if (line_count !== 9'd0 || pixel_count !== 17'd0 || frame_count !== 8'd0) begin n_bad++; $display("FAIL rmid_counts: got %0d/%0d/%0d want 0/0/0", line_count, pixel_count, frame_count); end
        n_cmp++; if (wr_bank !== 1'b0 || rd_bank !== DBUF) begin n_bad++; $display("FAIL rmid_banks: got wr=%b rd=%b want 0 %b", wr_bank, rd_bank, DBUF); end
        d0 = done_seen;
        reset = 1'b1;
        vsync = 1'b1;
        tick(3);
        n_cmp++; if (done_seen !== d0 || frame_done !== 1'b0) begin n_bad++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_seen - d0); end
    endtask

    task automatic test_wrap();
        int d0;
        d0 = done_seen;
        pulse_start(1'b1);
        for (int f = 0; f < 256; f++) begin
            if (f == 255) begin
                vblank();
                do_line(HP);
                stop = 1'b1;
                tick();
                stop = 1'b0;
                do_line(HP); do_line(HP);
                end_frame();
            end else begin
                frame(HP, HP, HP);
            end
            if (DBUF) exp_wr = ~exp_wr;
            if (f == 254) begin
                n_cmp++; if (frame_count !== 8'd255) begin n_bad++; $display("FAIL wrap_255: got %0d want 255", frame_count); end
            end
        end
        tick();
        n_cmp++; if (frame_count !== 8'd0) begin n_bad++; $display("FAIL wrap_zero: got %0d want 0", frame_count); end
        n_cmp++; if (done_seen - d0 !== 256) begin n_bad++; $display("FAIL wrap_done_cnt: got %0d want 256", done_seen - d0); end
        n_cmp++; if (busy !== 1'b0 || wr_bank !== exp_wr) begin n_bad++; $display("FAIL wrap_end: got busy=%b wr=%b want 0 %b", busy, wr_bank, exp_wr); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mid_start();
        test_short_line();
        test_continuous();
        test_start_stop();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
